// File: rtl/soml_hq_sched_if.sv
// Handshake bundle between the decoder controller, the Hq/Dh compute unit
// and the metric store, as seen by the Hq sequencer.
interface soml_hq_sched_if #(
  parameter int NQ = 4,
  parameter int DW = 16
);
  localparam int QW = (NQ > 1) ? $clog2(NQ) : 1;

  logic          req_valid;
  logic          req_ready;
  logic          abort;
  logic          core_start;
  logic          core_ready_hq;
  logic          core_done_dh;
  logic [DW-1:0] core_dh;
  logic [QW-1:0] q_idx;
  logic          dh_wr_en;
  logic [QW-1:0] dh_wr_addr;
  logic [DW-1:0] dh_wr_data;
  logic          busy;
  logic          pass_done;
  logic          err_timeout;
  logic [DW-1:0] dh_min;
  logic [QW-1:0] dh_min_idx;

  modport slave (
    input  req_valid, abort,
    input  core_ready_hq, core_done_dh, core_dh,
    output req_ready, core_start, q_idx,
    output dh_wr_en, dh_wr_addr, dh_wr_data,
    output busy, pass_done, err_timeout,
    output dh_min, dh_min_idx
  );

  modport master (
    output req_valid, abort,
    output core_ready_hq, core_done_dh, core_dh,
    input  req_ready, core_start, q_idx,
    input  dh_wr_en, dh_wr_addr, dh_wr_data,
    input  busy, pass_done, err_timeout,
    input  dh_min, dh_min_idx
  );
endinterface

// File: rtl/soml_hq_sched.sv
// Hq/Dh sequencer: runs NQ compute iterations per request, stores each D_h.
// Optional minimum tracking enabled by defining SOML_SCHED_MIN_TRACK_EN.
module soml_hq_sched #(
  parameter int NQ      = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64,
  parameter int SETTLE  = 1
) (
  input logic           clk,
  input logic           rst,
  soml_hq_sched_if.slave bus
);
  localparam int QW = (NQ > 1) ? $clog2(NQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_STORE,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t        state;
  logic [QW-1:0] q;
  logic          hq_prev;
  logic          dh_prev;
  logic          hq_seen;
  logic          dh_seen;
  logic [TW-1:0] to_cnt;
  logic [2:0]    st_cnt;
  logic          start_q;
  logic          wr_q;
  logic          done_q;
  logic          ready_q;
  logic          busy_q;
  logic          err_q;
  logic [DW-1:0] data_q;

  logic hq_rise;
  logic dh_rise;
  logic hq_any;
  logic dh_any;
  logic last_q;
  logic to_hit;
  logic kill;

  assign hq_rise = bus.core_ready_hq & ~hq_prev;
  assign dh_rise = bus.core_done_dh & ~dh_prev;
  assign hq_any  = hq_seen | hq_rise;
  assign dh_any  = dh_seen | dh_rise;
  assign last_q  = (q == QW'(NQ - 1));
  assign to_hit  = (to_cnt == TW'(TIMEOUT - 1));
  assign kill    = bus.abort & (state != S_IDLE);

  // Edge-detect history for the two completion flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hq_prev <= 1'b0;
      dh_prev <= 1'b0;
    end else begin
      hq_prev <= bus.core_ready_hq;
      dh_prev <= bus.core_done_dh;
    end
  end

  // Pass sequencer with registered strobes; abort wins over all moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      q       <= '0;
      hq_seen <= 1'b0;
      dh_seen <= 1'b0;
      to_cnt  <= '0;
      st_cnt  <= '0;
      start_q <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      start_q <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      if (kill) begin
        state   <= S_IDLE;
        ready_q <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (bus.req_valid) begin
              state   <= S_LAUNCH;
              q       <= '0;
              err_q   <= 1'b0;
              start_q <= 1'b1;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          S_LAUNCH: begin
            hq_seen <= 1'b0;
            dh_seen <= 1'b0;
            to_cnt  <= '0;
            state   <= S_WAIT;
          end
          S_WAIT: begin
            to_cnt <= to_cnt + 1'b1;
            if (hq_rise) hq_seen <= 1'b1;
            if (dh_rise) begin
              dh_seen <= 1'b1;
              if (!dh_seen) data_q <= bus.core_dh;
            end
            if (hq_any && dh_any) begin
              state <= S_STORE;
              wr_q  <= 1'b1;
            end else if (to_hit) begin
              err_q  <= 1'b1;
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end
          S_STORE: begin
            if (last_q) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              q <= q + 1'b1;
              if (SETTLE == 0) begin
                state   <= S_LAUNCH;
                start_q <= 1'b1;
              end else begin
                state  <= S_SETTLE;
                st_cnt <= '0;
              end
            end
          end
          S_SETTLE: begin
            st_cnt <= st_cnt + 1'b1;
            if (st_cnt == 3'(SETTLE - 1)) begin
              state   <= S_LAUNCH;
              start_q <= 1'b1;
            end
          end
          S_DONE: begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
          default: begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.busy        = busy_q;
  assign bus.core_start  = start_q;
  assign bus.q_idx       = q;
  assign bus.dh_wr_addr  = q;
  assign bus.dh_wr_data  = data_q;
  assign bus.dh_wr_en    = wr_q & ~bus.abort;
  assign bus.pass_done   = done_q & ~bus.abort;
  assign bus.err_timeout = err_q;

`ifdef SOML_SCHED_MIN_TRACK_EN
  logic [DW-1:0] run_min;
  logic [QW-1:0] run_idx;
  logic [DW-1:0] min_o;
  logic [QW-1:0] idx_o;

  // Running minimum over stored D_h; published only by a clean DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_min <= '0;
      run_idx <= '0;
      min_o   <= '0;
      idx_o   <= '0;
    end else if (!kill) begin
      if (state == S_LAUNCH && q == '0) begin
        run_min <= '1;
        run_idx <= '0;
      end else if (state == S_STORE && data_q < run_min) begin
        run_min <= data_q;
        run_idx <= q;
      end
      if (state == S_DONE && !err_q) begin
        min_o <= run_min;
        idx_o <= run_idx;
      end
    end
  end

  assign bus.dh_min     = min_o;
  assign bus.dh_min_idx = idx_o;
`else
  assign bus.dh_min     = '0;
  assign bus.dh_min_idx = '0;
`endif

endmodule

// File: tb/tb_soml_hq_sched.sv
// Randomised scoreboard bench for soml_hq_sched.
// Directed passes cover ordering, timeout, abort and async reset.
module tb_soml_hq_sched;
  localparam int NQ      = 4;
  localparam int DW      = 16;
  localparam int TIMEOUT = 64;
  localparam int SETTLE  = 1;

  typedef struct packed {
    logic [1:0]  a;
    logic [15:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  soml_hq_sched_if #(.NQ(NQ), .DW(DW)) bus ();

  soml_hq_sched #(
    .NQ(NQ), .DW(DW), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int starts_seen = 0;
  wr_t wq[$];
  bit  pq[$];

  logic [15:0] pd[NQ];
  int          ph[NQ];
  int          pdl[NQ];
  bit          pre_hq = 1'b0;
  logic [15:0] mmin = '0;
  logic [1:0]  midx = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard for store writes, pass_done and start pulses.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.core_start === 1'b1) starts_seen++;
        if (bus.dh_wr_en === 1'b1) begin
          chk("wr_addr_eq_q", 32'(bus.dh_wr_addr), 32'(bus.q_idx));
          if (wq.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                     bus.dh_wr_addr, bus.dh_wr_data);
          end else begin
            e = wq.pop_front();
            chk("wr_addr", 32'(bus.dh_wr_addr), 32'(e.a));
            chk("wr_data", 32'(bus.dh_wr_data), 32'(e.d));
          end
        end
        if (bus.pass_done === 1'b1) begin
          if (pq.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_pass_done: got 1, expected 0");
          end else begin
            chk("err_at_done", 32'(bus.err_timeout), 32'(pq.pop_front()));
          end
        end
      end
    end
  end

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.core_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      nchk++;
      nerr++;
      $display("FAIL start_wait: no core_start, expected one");
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      nchk++;
      nerr++;
      $display("FAIL idle_wait: req_ready stuck 0, expected 1");
    end
  endtask

  // Compute-unit model: flags as short pulses, c cycles after the start.
  task automatic drive_iter(input int h, input int d,
                            input logic [15:0] v, input bit omit,
                            input bit pre);
    int lh;
    int ld;
    int last;
    lh = $urandom_range(1, 2);
    ld = $urandom_range(1, 2);
    last = h + lh;
    if (!omit && d + ld > last) last = d + ld;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      bus.core_ready_hq = (c >= h && c < h + lh) || (pre && c == 1);
      bus.core_done_dh  = !omit && c >= d && c < d + ld;
      bus.core_dh       = (c == d) ? v : 16'($urandom);
    end
  endtask

  task automatic recover();
    rst = 1'b0;
    #2;
    wq.delete();
    pq.delete();
    mmin = '0;
    midx = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // One pass; tq = timeout at q, aq = abort at q, rq = reset at q.
  task automatic do_pass(input int tq, input int aq, input int rq);
    int stopq;
    int launched;
    int base;
    int pstart;
    int pm;
    int h;
    int d;
    bit ok;
    bit cut;
    logic [15:0] best;
    stopq = NQ;
    if (tq >= 0) stopq = tq;
    if (aq >= 0) stopq = aq;
    if (rq >= 0) stopq = rq;
    for (int q = 0; q < stopq; q++) wq.push_back('{a: 2'(q), d: pd[q]});
    if (aq < 0 && rq < 0) pq.push_back(tq >= 0);
    launched = (stopq == NQ) ? NQ : stopq + 1;
    base = starts_seen;
    pstart = 0;
    pm = 0;
    cut = 1'b0;
    if (pre_hq) bus.core_ready_hq = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int q = 0; q < launched; q++) begin
      wait_start(ok);
      if (!ok) begin
        recover();
        return;
      end
      chk("q_idx_at_start", 32'(bus.q_idx), 32'(q));
      if (q == 0) chk("err_clear", 32'(bus.err_timeout), 32'd0);
      else chk("iter_spacing", 32'(cyc - pstart), 32'(pm + 3));
      pstart = cyc;
      if (q == aq) begin
        repeat (2) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        cut = 1'b1;
        break;
      end
      if (q == rq) begin
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_start", 32'(bus.core_start), 32'd0);
        chk("rst_wr_en", 32'(bus.dh_wr_en), 32'd0);
        chk("rst_done", 32'(bus.pass_done), 32'd0);
        chk("rst_q_idx", 32'(bus.q_idx), 32'd0);
        chk("rst_wr_data", 32'(bus.dh_wr_data), 32'd0);
        chk("rst_err", 32'(bus.err_timeout), 32'd0);
        chk("rst_min", 32'(bus.dh_min), 32'd0);
        mmin = '0;
        midx = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 32'(bus.req_ready), 32'd1);
        cut = 1'b1;
        break;
      end
      h = ph[q];
      d = pdl[q];
      pm = (h > d) ? h : d;
      if (q == tq) begin
        drive_iter(h, 0, 16'd0, 1'b1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (bus.pass_done === 1'b1) begin
            ok = 1'b1;
            break;
          end
        end
        chk("timeout_seen", 32'(ok), 32'd1);
        chk("timeout_cycles", 32'(cyc - pstart), 32'(TIMEOUT + 1));
      end else begin
        drive_iter(h, d, pd[q], 1'b0, pre_hq && q == 0);
      end
    end
    pre_hq = 1'b0;
    wait_idle(ok);
    @(negedge clk);
    chk("start_count", 32'(starts_seen - base), 32'(launched));
    chk("wr_queue_empty", 32'(wq.size()), 32'd0);
    chk("done_queue_empty", 32'(pq.size()), 32'd0);
    if (!cut && tq < 0) begin
      best = pd[0];
      for (int q = 1; q < NQ; q++) if (pd[q] < best) best = pd[q];
      for (int q = NQ - 1; q >= 0; q--) if (pd[q] == best) midx = 2'(q);
      mmin = best;
    end
`ifdef SOML_SCHED_MIN_TRACK_EN
    chk("dh_min", 32'(bus.dh_min), 32'(mmin));
    chk("dh_min_idx", 32'(bus.dh_min_idx), 32'(midx));
`else
    chk("dh_min_off", 32'(bus.dh_min), 32'd0);
    chk("dh_min_idx_off", 32'(bus.dh_min_idx), 32'd0);
`endif
    wq.delete();
    pq.delete();
  endtask

  task automatic set_pass(input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3);
    pd[0] = d0;
    pd[1] = d1;
    pd[2] = d2;
    pd[3] = d3;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: run still active, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bus.req_valid     = 1'b0;
    bus.abort         = 1'b0;
    bus.core_ready_hq = 1'b0;
    bus.core_done_dh  = 1'b0;
    bus.core_dh       = '0;
    #12;
    chk("init_ready", 32'(bus.req_ready), 32'd1);
    chk("init_busy", 32'(bus.busy), 32'd0);
    chk("init_start", 32'(bus.core_start), 32'd0);
    chk("init_wr_en", 32'(bus.dh_wr_en), 32'd0);
    chk("init_done", 32'(bus.pass_done), 32'd0);
    chk("init_err", 32'(bus.err_timeout), 32'd0);
    chk("init_q_idx", 32'(bus.q_idx), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    set_pass(16'h0120, 16'h0080, 16'h0300, 16'h0040);
    for (int q = 0; q < NQ; q++) begin
      ph[q] = 3;
      pdl[q] = 5;
    end
    do_pass(-1, -1, -1);

    set_pass(16'h1111, 16'h2222, 16'h0333, 16'h0444);
    ph[0] = 5; pdl[0] = 2;
    ph[1] = 3; pdl[1] = 3;
    ph[2] = 1; pdl[2] = 1;
    ph[3] = 1; pdl[3] = 1;
    pre_hq = 1'b1;
    do_pass(-1, -1, -1);

    set_pass(16'h0500, 16'h0600, 16'h0001, 16'h0700);
    for (int q = 0; q < NQ; q++) begin
      ph[q] = 2;
      pdl[q] = 4;
    end
    do_pass(2, -1, -1);

    set_pass(16'h0040, 16'h0040, 16'h0100, 16'h0200);
    do_pass(-1, -1, -1);

    set_pass(16'h0010, 16'h0020, 16'h0030, 16'h0050);
    do_pass(-1, 1, -1);

    for (int n = 0; n < 16; n++) begin
      for (int q = 0; q < NQ; q++) begin
        pd[q]  = (n % 4 == 3) ? 16'($urandom_range(0, 3)) : 16'($urandom);
        ph[q]  = $urandom_range(1, 8);
        pdl[q] = $urandom_range(1, 8);
      end
      if ($urandom_range(0, 5) == 0) do_pass(-1, $urandom_range(0, 3), -1);
      else do_pass(-1, -1, -1);
    end

    set_pass(16'h0abc, 16'h0def, 16'h0123, 16'h0456);
    for (int q = 0; q < NQ; q++) begin
      ph[q] = 2;
      pdl[q] = 3;
    end
    do_pass(-1, -1, 1);

    set_pass(16'hffff, 16'hffff, 16'hffff, 16'hffff);
    do_pass(-1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/soml_hq_sched.md
Name: soml_hq_sched

Overview:
Sequencer for the SOML decoder Hq/Dh compute unit (Hq_Dh_cal).
- On one request it runs NQ back-to-back iterations, one per Hq candidate index q.
- For each q it pulses the unit's start input and waits for both completion flags (row-Hq ready and Dh done). It then writes the resulting D_h into the downstream metric store at address q.
- Sits between the decoder top-level controller and the compute unit. Provides a watchdog timeout and an abort path.

Parameters:
- NQ, 4, iterations per pass (candidate Hq count); range 2..16.
- DW, 16, D_h width (Q8.8 fixed point).
- TIMEOUT, 64, max WAIT cycles per iteration before error.
- SETTLE, 1, idle cycles between STORE and the next LAUNCH (0..7).

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-low reset.
- req_valid, input, 1, request one full pass.
- req_ready, output, 1, high only in IDLE.
- abort, input, 1, cancel the current pass.
- core_start, output, 1, one-cycle start pulse to the compute unit.
- core_ready_hq, input, 1, row-Hq finished flag from the compute unit.
- core_done_dh, input, 1, D_h accumulation finished flag from the compute unit.
- core_dh, input, DW, D_h result.
- q_idx, output, $clog2(NQ), current candidate index.
- dh_wr_en, output, 1, metric store write strobe.
- dh_wr_addr, output, $clog2(NQ), write address; equals q_idx.
- dh_wr_data, output, DW, registered copy of core_dh.
- busy, output, 1, high in any state other than IDLE.
- pass_done, output, 1, one-cycle pulse at end of pass.
- err_timeout, output, 1, sticky error flag.
- dh_min, output, DW, minimum D_h of last pass (optional feature).
- dh_min_idx, output, $clog2(NQ), index of that minimum (optional feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs 0, except req_ready=1.
  - q_idx=0, flag latches clear, counters 0.
- States: IDLE, LAUNCH, WAIT, STORE, SETTLE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at edge T: go to LAUNCH, q_idx<=0, clear err_timeout.
- LAUNCH:
  - core_start=1 for exactly this one cycle (first pulse at T+1).
  - Clear hq_seen, dh_seen and the timeout counter; go to WAIT.
- WAIT:
  - Flag capture:
    - Each flag is captured on its rising edge (compared with the previous-cycle registered value).
    - A flag already high on entry to WAIT does not count.
    - Captures go into sticky latches hq_seen and dh_seen.
    - The two flags may arrive in either order or in the same cycle.
    - core_dh is captured into dh_wr_data in the cycle the dh rising edge is seen.
  - When both latches are set (including on the capture cycle itself): go to STORE.
  - Timeout counter increments every WAIT cycle. On reaching TIMEOUT-1 with either latch clear:
    - err_timeout<=1.
    - No write for this q or any remaining q.
    - Go to DONE.
- STORE:
  - dh_wr_en=1 for one cycle, with addr=q_idx and data=dh_wr_data.
  - If q_idx==NQ-1: go to DONE.
  - Else: q_idx<=q_idx+1; go to SETTLE (or straight to LAUNCH if SETTLE=0).
- SETTLE: wait SETTLE cycles, then go to LAUNCH.
- DONE:
  - pass_done=1 for one cycle, then IDLE.
  - q_idx holds its last value until the next request.
- abort=1 in any non-IDLE state:
  - Next state is IDLE.
  - No pass_done; no dh_wr_en in that cycle; err_timeout unchanged.
  - abort has priority over every other transition.
- req_valid while busy is ignored (req_ready=0). A request presented in the DONE cycle is accepted on the following IDLE cycle.
- Best-case per-iteration latency (both flags at the first WAIT cycle): LAUNCH, WAIT, STORE, SETTLE = 3+SETTLE cycles.
- err_timeout stays set until the next accepted request.

Optional Feature:
Macro SOML_SCHED_MIN_TRACK_EN.
- Defined:
  - At LAUNCH of q=0 the running minimum is preset to all ones.
  - Each STORE compares dh_wr_data unsigned against the running minimum. If strictly less, the minimum and its index update; ties keep the lower index.
  - dh_min/dh_min_idx update to the final values at DONE and hold until the next DONE.
  - A timed-out or aborted pass leaves them unchanged.
- Not defined: dh_min and dh_min_idx are tied to 0 and no compare logic is built.

Test Plan:
1. NQ=4, SETTLE=1. req at T; for each q, ready_hq then done_dh 5 cycles after core_start, with core_dh=0x0120,0x0080,0x0300,0x0040 -> four core_start pulses; writes at addr 0..3 with those data; pass_done once; err_timeout=0.
2. done_dh arrives 3 cycles before ready_hq, then same-cycle arrival -> STORE only after both flags seen; data equals core_dh sampled at the done_dh edge.
3. Never assert done_dh at q=2, TIMEOUT=64 -> err_timeout=1 after 64 WAIT cycles; writes only for q=0,1; pass_done pulses; err_timeout clears on the next request.
4. abort during WAIT of q=1 -> IDLE next cycle; no pass_done; no further writes; req_ready=1; a new req restarts at q=0.
5. rst low mid-WAIT -> all outputs reset immediately (asynchronously); req_ready=1 after release.
6. With SOML_SCHED_MIN_TRACK_EN and the data from test 1 -> dh_min=0x0040, dh_min_idx=3. Repeat with data 0x0040,0x0040,0x0100,0x0200 -> dh_min_idx=0.
